fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the 5-stage RV32I pipeline. It sequences the program counter and issues reads to a synchronous instruction memory with a one-cycle read latency. It registers each fetched word with its PC into the IF/ID pipeline register, and that register feeds the decode/control stage. It honours stalls from the hazard unit and flushes on taken branches resolved in EX, using a one-entry skid buffer so that no instruction is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold IF/ID and PC (from hazard unit)
- branch_taken  in  1  redirect fetch, kill younger instructions (from EX)
- branch_target  in  32  redirect byte address; bits [1:0] ignored (treated as 0)
- imem_en  out  1  read request this cycle
- imem_addr  out  32  byte address of the request
- imem_rdata  in  32  read data; valid the cycle after the request
- if_id  out  if_id_type  {pc[31:0], instruction (instruction_type), valid}

## Operation
- Registers:
  - fetch_pc: the next address to request.
  - req_pc / req_live: tracks the single in-flight request.
  - skid buffer: one entry, holding {pc, word, full}.
  - if_id output register.
- Request: imem_en = !stall; imem_addr = fetch_pc. When a request issues, fetch_pc <= fetch_pc + 4 (mod 2^32, so 0xFFFF_FFFC wraps to 0), req_pc <= fetch_pc, req_live <= 1. With no request, req_live <= 0.
- Response: in the cycle after a live request, {req_pc, imem_rdata} is the returned instruction.
- stall=0:
  - If the skid is full, if_id <= skid entry (valid=1) and the skid empties.
  - Otherwise, if req_live, if_id <= response (valid=1).
  - Otherwise, if_id.valid <= 0 and instruction <= NOP.
- Skid and response in the same cycle: cannot occur. A request is blocked during stall, so the skid fills only from the single in-flight response.
- stall=1:
  - if_id and fetch_pc hold.
  - A live response is written into the skid buffer.
  - No new request issues.
- branch_taken=1 has priority over stall:
  - fetch_pc <= {branch_target[31:2], 2'b00}.
  - req_live <= 0, so any response next cycle is discarded.
  - The skid empties.
  - if_id.valid <= 0, if_id.instruction <= NOP_INSTRUCTION.
  - imem_en follows the normal rule, but any request issued this cycle is killed.
- An invalid if_id always carries NOP_INSTRUCTION (32'h0000_0013, addi x0,x0,0) and pc 0. Decode therefore needs no valid gating.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; req_live = 0; skid empty.
  - if_id = {pc 0, NOP, valid 0}.
  - imem_en = 0 during reset, imem_addr = RESET_PC.
- Latency: request at cycle t; word in if_id after the edge ending t+1. The first valid if_id appears 2 cycles after reset deasserts.
- Throughput: 1 instruction/cycle with no stall.
- After stall release, if_id advances on the first edge with no bubble, because the skid refills the pipe.
- Branch penalty: flush edge at cycle t; the target is requested in t+1; target valid in if_id after the edge ending t+2. Exactly 2 bubbles.
- Reset mid-stall or with a full skid: everything returns to reset values on that edge. Reset dominates branch_taken and stall.

## Structure
- Package common:
  - if_id_type struct.
  - NOP_INSTRUCTION constant.
  - PC_INCREMENT = 4.
- Sub-module skid_buffer:
  - Ports: clk, reset, load, data_in{pc, word}, pop, clear, full, data_out.
  - Single entry; clear has priority over load; load when full is illegal (assert).

## Test plan
- Reset with RESET_PC=0, memory returning word = address, no stall:
  - if_id.valid rises 2 cycles after reset.
  - pc/instruction run 0,4,8,12 on consecutive cycles.
- Stall held 3 cycles while if_id.pc=8:
  - if_id holds 8 for 3 cycles.
  - Then 12, 16 back-to-back; no drop or duplicate; imem_en=0 during stall.
- branch_taken with target 0x40, asserted together with stall:
  - Next 2 cycles valid=0, instruction=32'h13.
  - Then pc 0x40, 0x44.
  - The stale in-flight word never appears.
- Misaligned target 0x43: imem_addr 0x40, then if_id.pc=0x40.
- RESET_PC=0xFFFF_FFF8: if_id.pc sequence FFF8, FFFC, 0000_0000, 0000_0004.
- Reset asserted during stall with skid full:
  - Next cycle if_id={0, NOP, 0} and imem_addr=RESET_PC.
  - The sequence restarts cleanly after deassert.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the IF/ID bundle, the skid entry and the NOP encoding.
package common;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [31:0] PC_INCREMENT    = 32'd4;

  typedef logic [31:0] instruction_type;

  typedef struct packed {
    logic [31:0]     pc;
    instruction_type instruction;
    logic            valid;
  } if_id_type;

  typedef struct packed {
    logic [31:0]     pc;
    instruction_type word;
  } fetch_entry_type;

  localparam if_id_type IF_ID_BUBBLE = '{
    pc:          32'h0,
    instruction: NOP_INSTRUCTION,
    valid:       1'b0
  };

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry skid buffer catching the in-flight fetch response
// when the stage is stalled.
module skid_buffer
  import common::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  fetch_entry_type data_in,
  input  logic            pop,
  input  logic            clear,
  output logic            full,
  output fetch_entry_type data_out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= 1'b0;
      data_out <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      data_out <= data_in;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  a_no_overfill : assert property (
    @(posedge clk) disable iff (reset) !(load && full)
  );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, one-cycle imem reads,
// IF/ID register with stall skid and branch flush.
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output if_id_type   if_id
);

  logic [31:0]     fetch_pc;
  logic [31:0]     req_pc;
  logic            req_live;
  logic            skid_full;
  logic            skid_load;
  logic            skid_pop;
  fetch_entry_type resp;
  fetch_entry_type skid_out;
  logic            unused_bits;

  assign unused_bits = ^branch_target[1:0];

  assign imem_en   = !stall && !reset;
  assign imem_addr = reset ? RESET_PC : fetch_pc;

  assign resp      = '{pc: req_pc, word: imem_rdata};
  assign skid_load = stall && req_live && !branch_taken;
  assign skid_pop  = !stall && skid_full && !branch_taken;

  skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .data_in  (resp),
    .pop      (skid_pop),
    .clear    (branch_taken),
    .full     (skid_full),
    .data_out (skid_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      req_live <= 1'b0;
      if_id    <= IF_ID_BUBBLE;
    end else if (branch_taken) begin
      // a request issued this cycle is dropped via req_live
      fetch_pc <= {branch_target[31:2], 2'b00};
      req_live <= 1'b0;
      if_id    <= IF_ID_BUBBLE;
    end else if (stall) begin
      req_live <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc + PC_INCREMENT;
      req_pc   <= fetch_pc;
      req_live <= 1'b1;
      unique case (1'b1)
        skid_full: if_id <= '{
          pc:          skid_out.pc,
          instruction: skid_out.word,
          valid:       1'b1
        };
        req_live: if_id <= '{
          pc:          resp.pc,
          instruction: resp.word,
          valid:       1'b1
        };
        default: if_id <= IF_ID_BUBBLE;
      endcase
    end
  end

endmodule
